// File: rtl/uart_tx_frame.sv
// UART transmitter: one character per VALID_I/READY_TX handshake, run-time length,
// parity mode, stop count and baud divisor, all latched when the character is accepted.
module uart_tx_frame #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 12
) (
  input  logic              PCLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DATA_TX_I,
  input  logic              VALID_I,
  output logic              READY_TX,
  input  logic [3:0]        DATA_BITS_I,
  input  logic [1:0]        PARITY_I,
  input  logic              STOP2_I,
  input  logic [DIV_W-1:0]  BAUD_DIV_I,
  output logic              TX_O,
  output logic              BUSY_O,
  output logic              DONE_O
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t            state_reg;
  logic [DATA_W-1:0] shreg_reg;
  logic [3:0]        len_reg;
  logic              par_en_reg;
  logic              par_bit_reg;
  logic              stop2_reg;
  logic [DIV_W-1:0]  div_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [3:0]        bit_cnt_reg;
  logic              stop_cnt_reg;
  logic              tx_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [3:0]        len_next;
  logic [DATA_W-1:0] data_mask;
  logic              par_bit_next;
  logic              par_en_next;
  logic              bit_end;
  logic              last_stop;
  logic              accept;

  always_comb begin
    len_next = DATA_BITS_I;
    if (DATA_BITS_I < 4'd5)
      len_next = 4'd5;
    else if (DATA_BITS_I > 4'(DATA_W))
      len_next = 4'(DATA_W);
  end

  // Parity comes from the input word masked to the effective length, not the shifter.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
      assign data_mask[gi] = (4'(gi) < len_next);
    end
  endgenerate

  assign par_bit_next = (^(DATA_TX_I & data_mask)) ^ (PARITY_I == 2'b10);
  assign par_en_next  = (PARITY_I == 2'b01) || (PARITY_I == 2'b10);

  assign bit_end   = (div_cnt_reg == div_reg);
  assign last_stop = (state_reg == ST_STOP) && bit_end && (stop_cnt_reg == stop2_reg);

  // Ready during the final stop cycle too, so a waiting character starts with no gap.
  assign READY_TX = (state_reg == ST_IDLE) || last_stop;
  assign accept   = VALID_I && READY_TX;

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state_reg    <= ST_IDLE;
      shreg_reg    <= '0;
      len_reg      <= '0;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
      div_reg      <= '0;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg != ST_IDLE)
        div_cnt_reg <= bit_end ? '0 : div_cnt_reg + 1'b1;

      case (state_reg)
        ST_IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
        end
        ST_START: begin
          if (bit_end) begin
            state_reg <= ST_DATA;
            tx_reg    <= shreg_reg[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt_reg == len_reg - 4'd1) begin
              if (par_en_reg) begin
                state_reg <= ST_PARITY;
                tx_reg    <= par_bit_reg;
              end else begin
                state_reg <= ST_STOP;
                tx_reg    <= 1'b1;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              shreg_reg   <= shreg_reg >> 1;
              tx_reg      <= shreg_reg[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state_reg <= ST_STOP;
            tx_reg    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (stop_cnt_reg == stop2_reg) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              tx_reg    <= 1'b1;
            end else begin
              stop_cnt_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          tx_reg      <= 1'b1;
          busy_reg    <= 1'b0;
          div_cnt_reg <= '0;
        end
      endcase

      // Acceptance overrides the idle/stop bookkeeping above; DONE_O still pulses.
      if (accept) begin
        shreg_reg    <= DATA_TX_I;
        len_reg      <= len_next;
        par_en_reg   <= par_en_next;
        par_bit_reg  <= par_bit_next;
        stop2_reg    <= STOP2_I;
        div_reg      <= BAUD_DIV_I;
        div_cnt_reg  <= '0;
        bit_cnt_reg  <= '0;
        stop_cnt_reg <= 1'b0;
        state_reg    <= ST_START;
        tx_reg       <= 1'b0;
        busy_reg     <= 1'b1;
      end
    end
  end

  assign TX_O   = tx_reg;
  assign BUSY_O = busy_reg;
  assign DONE_O = done_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: per-cycle line sampling against hand-computed frames.
module tb_uart_tx_frame;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 12;

  logic              PCLK = 1'b0;
  logic              RESET = 1'b1;
  logic [DATA_W-1:0] DATA_TX_I = '0;
  logic              VALID_I = 1'b0;
  logic              READY_TX;
  logic [3:0]        DATA_BITS_I = 4'd8;
  logic [1:0]        PARITY_I = 2'b00;
  logic              STOP2_I = 1'b0;
  logic [DIV_W-1:0]  BAUD_DIV_I = '0;
  logic              TX_O;
  logic              BUSY_O;
  logic              DONE_O;

  int checks_total = 0;
  int checks_passed = 0;

  uart_tx_frame #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .PCLK        (PCLK),
    .RESET       (RESET),
    .DATA_TX_I   (DATA_TX_I),
    .VALID_I     (VALID_I),
    .READY_TX    (READY_TX),
    .DATA_BITS_I (DATA_BITS_I),
    .PARITY_I    (PARITY_I),
    .STOP2_I     (STOP2_I),
    .BAUD_DIV_I  (BAUD_DIV_I),
    .TX_O        (TX_O),
    .BUSY_O      (BUSY_O),
    .DONE_O      (DONE_O)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      checks_passed++;
  endtask

  // Sends one frame; exp_seq holds the line level of each bit period, bit 0 first in time.
  task automatic run_frame(input string tag, input logic [7:0] data, input logic [3:0] bits,
                           input logic [1:0] par, input logic stop2, input int div,
                           input int nbits, input logic [31:0] exp_seq);
    int per;
    int f;
    int bad;
    int busy_cnt;
    int early_done;
    logic [31:0] obs;
    per = div + 1;
    f = nbits * per;
    bad = 0;
    busy_cnt = 0;
    early_done = 0;
    obs = '0;
    @(negedge PCLK);
    check({tag, "_ready_before"}, 32'(READY_TX), 32'd1);
    DATA_TX_I   = data;
    DATA_BITS_I = bits;
    PARITY_I    = par;
    STOP2_I     = stop2;
    BAUD_DIV_I  = DIV_W'(div);
    VALID_I     = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    VALID_I   = 1'b0;
    DATA_TX_I = ~data;
    check({tag, "_ready_after"}, 32'(READY_TX), 32'd0);
    for (int t = 0; t < f; t++) begin
      if (t % per == 0)
        obs[t / per] = TX_O;
      else if (TX_O !== obs[t / per])
        bad++;
      if (BUSY_O === 1'b1) busy_cnt++;
      if (DONE_O !== 1'b0) early_done++;
      if (t == 2 * per) begin
        PARITY_I    = ~par;
        STOP2_I     = ~stop2;
        BAUD_DIV_I  = DIV_W'(div + 2);
        DATA_BITS_I = bits ^ 4'h3;
      end
      @(negedge PCLK);
    end
    check({tag, "_seq"}, obs, exp_seq);
    check({tag, "_held"}, 32'(bad), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(f));
    check({tag, "_early_done"}, 32'(early_done), 32'd0);
    check({tag, "_done"}, 32'(DONE_O), 32'd1);
    check({tag, "_busy_end"}, 32'(BUSY_O), 32'd0);
    check({tag, "_ready_end"}, 32'(READY_TX), 32'd1);
    check({tag, "_tx_idle"}, 32'(TX_O), 32'd1);
    @(negedge PCLK);
    check({tag, "_done_pulse"}, 32'(DONE_O), 32'd0);
    $display("frame %s: data=%02h len=%0d par=%0d stop2=%0d div=%0d F=%0d", tag, data, bits, par,
             stop2, div, f);
  endtask

  initial begin
    int bad;
    int busy_cnt;
    int done_cnt;
    logic [31:0] obs;

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    RESET = 1'b0;
    check("rst_tx", 32'(TX_O), 32'd1);
    check("rst_ready", 32'(READY_TX), 32'd1);
    check("rst_busy", 32'(BUSY_O), 32'd0);
    check("rst_done", 32'(DONE_O), 32'd0);

    run_frame("8N1_55",    8'h55, 4'd8,  2'b00, 1'b0, 3, 10, 32'h2AA);
    run_frame("8E1_07",    8'h07, 4'd8,  2'b01, 1'b0, 0, 11, 32'h60E);
    run_frame("8O1_07",    8'h07, 4'd8,  2'b10, 1'b0, 0, 11, 32'h40E);
    run_frame("7O2_FF",    8'hFF, 4'd7,  2'b10, 1'b1, 1, 11, 32'h6FE);
    run_frame("clamp5_E6", 8'hE6, 4'd2,  2'b00, 1'b0, 0, 7,  32'h04C);
    run_frame("clamp8_80", 8'h80, 4'd15, 2'b01, 1'b0, 0, 11, 32'h700);
    run_frame("par11_55",  8'h55, 4'd8,  2'b11, 1'b0, 0, 10, 32'h2AA);

    // Back-to-back: 0xA5 then 0x3C, 8N1, D=2, VALID_I held across the boundary.
    @(negedge PCLK);
    DATA_TX_I   = 8'hA5;
    DATA_BITS_I = 4'd8;
    PARITY_I    = 2'b00;
    STOP2_I     = 1'b0;
    BAUD_DIV_I  = DIV_W'(2);
    VALID_I     = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    DATA_TX_I = 8'h3C;
    bad = 0;
    busy_cnt = 0;
    done_cnt = 0;
    obs = '0;
    for (int t = 0; t < 60; t++) begin
      if (t % 3 == 0)
        obs[t / 3] = TX_O;
      else if (TX_O !== obs[t / 3])
        bad++;
      if (BUSY_O === 1'b1) busy_cnt++;
      if (t == 30) begin
        check("b2b_done_at_boundary", 32'(DONE_O), 32'd1);
        check("b2b_start_at_boundary", 32'(TX_O), 32'd0);
        check("b2b_busy_at_boundary", 32'(BUSY_O), 32'd1);
        VALID_I = 1'b0;
      end else if (DONE_O !== 1'b0) begin
        done_cnt++;
      end
      @(negedge PCLK);
    end
    check("b2b_seq", obs, {12'h0, 10'h278, 10'h34A});
    check("b2b_held", 32'(bad), 32'd0);
    check("b2b_busy_cycles", 32'(busy_cnt), 32'd60);
    check("b2b_stray_done", 32'(done_cnt), 32'd0);
    check("b2b_done_end", 32'(DONE_O), 32'd1);
    check("b2b_busy_end", 32'(BUSY_O), 32'd0);
    $display("frame b2b: data=A5,3C 8N1 div=2");

    // Reset during data bit 3 of a 0x55 frame with D=1 (cycles 8..9 after accept).
    @(negedge PCLK);
    DATA_TX_I  = 8'h55;
    BAUD_DIV_I = DIV_W'(1);
    VALID_I    = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    VALID_I = 1'b0;
    repeat (8) @(negedge PCLK);
    check("rstmid_busy_before", 32'(BUSY_O), 32'd1);
    RESET = 1'b1;
    @(negedge PCLK);
    RESET = 1'b0;
    check("rstmid_tx", 32'(TX_O), 32'd1);
    check("rstmid_ready", 32'(READY_TX), 32'd1);
    check("rstmid_busy", 32'(BUSY_O), 32'd0);
    check("rstmid_done", 32'(DONE_O), 32'd0);
    done_cnt = 0;
    for (int t = 0; t < 30; t++) begin
      if (DONE_O !== 1'b0) done_cnt++;
      @(negedge PCLK);
    end
    check("rstmid_no_done", 32'(done_cnt), 32'd0);
    $display("frame reset_abort: data=55 abandoned");

    run_frame("after_rst_55", 8'h55, 4'd8, 2'b00, 1'b0, 3, 10, 32'h2AA);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
